// File: rtl/reg_write_ctrl.sv
// reg_write_ctrl: owns the single write port of the pipeline register file.
// After reset it sweeps zeros into every entry. It then acts as the MEM/WB
// writeback register: it picks ALU or load data, drops writes to $zero,
// exports a forwarding copy of the in-flight write and counts retired writes.
module reg_write_ctrl #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5,
    parameter bit CLEAR_EN = 1'b1,
    parameter int CWIDTH   = 16
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [AWIDTH-1:0] in_rd,
    input  logic [DWIDTH-1:0] in_alu_result,
    input  logic [DWIDTH-1:0] in_mem_data,
    output logic              r_wr_en,
    output logic [AWIDTH-1:0] r_addr_in,
    output logic [DWIDTH-1:0] r_data_in,
    output logic              fwd_valid,
    output logic [AWIDTH-1:0] fwd_addr,
    output logic [DWIDTH-1:0] fwd_data,
    output logic              init_done,
    output logic [CWIDTH-1:0] wb_count
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [AWIDTH:0]   CNT_ONE = 1;
    localparam logic [CWIDTH-1:0] WB_ONE  = 1;

    state_t            state_reg, state_next;
    // One extra bit: the MSB rises after the last address has been issued,
    // which gives the extra edge that leaves CLEAR with r_wr_en low.
    logic [AWIDTH:0]   cnt_reg;
    logic              sweep_end;
    logic              accept;
    logic              issue;
    logic              wb_sat;
    logic [DWIDTH-1:0] wb_data;

    assign sweep_end = cnt_reg[AWIDTH];
    // Reset is folded in so that a CLEAR_EN=0 build does not advertise
    // readiness while it is held in reset.
    assign in_ready  = (state_reg == RUN) && !r_rst;
    assign accept    = in_valid && in_ready;
    assign issue     = in_reg_write && (in_rd != '0);
    assign wb_sat    = &wb_count;
    assign wb_data   = in_mem_to_reg ? in_mem_data : in_alu_result;

    // Clear writes are kept out of the forwarding path: r_wr_en is only ever
    // high in RUN for genuine writebacks, because the edge that enters RUN
    // also drops r_wr_en.
    assign fwd_valid = r_wr_en && (state_reg == RUN);
    assign fwd_addr  = r_addr_in;
    assign fwd_data  = r_data_in;

    // State register
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            state_reg <= CLEAR_EN ? CLEAR : RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state: leave CLEAR once every address has been written
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CLEAR:   if (sweep_end) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = state_reg;
        endcase
    end

    // Write port, sweep counter, init flag and retired-write counter
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            cnt_reg   <= '0;
            r_wr_en   <= 1'b0;
            r_addr_in <= '0;
            r_data_in <= '0;
            init_done <= 1'b0;
            wb_count  <= '0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    if (!sweep_end) begin
                        r_wr_en   <= 1'b1;
                        r_addr_in <= cnt_reg[AWIDTH-1:0];
                        r_data_in <= '0;
                        cnt_reg   <= cnt_reg + CNT_ONE;
                    end else begin
                        r_wr_en   <= 1'b0;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    init_done <= 1'b1;
                    if (accept) begin
                        r_wr_en   <= issue;
                        r_addr_in <= in_rd;
                        r_data_in <= wb_data;
                        if (issue && !wb_sat) begin
                            wb_count <= wb_count + WB_ONE;
                        end
                    end else begin
                        // Address and data hold; only the enable drops.
                        r_wr_en <= 1'b0;
                    end
                end
                default: r_wr_en <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Directed testbench for reg_write_ctrl. A default instance (with clear sweep)
// is checked against hand-computed values. A second instance with CLEAR_EN=0
// and a 3-bit counter is used for the immediate-RUN and saturation cases.
module tb_reg_write_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        sat_valid;
    logic        in_reg_write;
    logic        in_mem_to_reg;
    logic [4:0]  in_rd;
    logic [31:0] in_alu_result;
    logic [31:0] in_mem_data;

    logic        in_ready, r_wr_en, fwd_valid, init_done;
    logic [4:0]  r_addr_in, fwd_addr;
    logic [31:0] r_data_in, fwd_data;
    logic [15:0] wb_count;

    logic        s_in_ready, s_wr_en, s_fwd_valid, s_init_done;
    logic [4:0]  s_addr, s_fwd_addr;
    logic [31:0] s_data, s_fwd_data;
    logic [2:0]  s_wb_count;

    int checks   = 0;
    int failures = 0;

    // Register file model fed by the DUT write port, used for readback
    logic [31:0] rf [32];
    logic        rf_scramble;

    reg_write_ctrl u_dut (
        .r_clk(clk), .r_rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_rd(in_rd), .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .r_wr_en(r_wr_en), .r_addr_in(r_addr_in), .r_data_in(r_data_in),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .init_done(init_done), .wb_count(wb_count)
    );

    reg_write_ctrl #(.CLEAR_EN(1'b0), .CWIDTH(3)) u_sat (
        .r_clk(clk), .r_rst(rst),
        .in_valid(sat_valid), .in_ready(s_in_ready),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
        .in_rd(in_rd), .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
        .r_wr_en(s_wr_en), .r_addr_in(s_addr), .r_data_in(s_data),
        .fwd_valid(s_fwd_valid), .fwd_addr(s_fwd_addr), .fwd_data(s_fwd_data),
        .init_done(s_init_done), .wb_count(s_wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the register file's write port
    always @(posedge clk) begin
        if (rf_scramble) begin
            for (int k = 0; k < 32; k++) rf[k] <= 32'hA5A5_A5A5;
        end else if (r_wr_en) begin
            rf[r_addr_in] <= r_data_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_port(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_wr_en"}, {31'd0, r_wr_en}, {31'd0, en});
        chk({tag, "_addr"}, {27'd0, r_addr_in}, {27'd0, a});
        chk({tag, "_data"}, r_data_in, d);
        chk({tag, "_fwd_valid"}, {31'd0, fwd_valid}, {31'd0, en});
        chk({tag, "_fwd_addr"}, {27'd0, fwd_addr}, {27'd0, a});
        chk({tag, "_fwd_data"}, fwd_data, d);
    endtask

    initial begin
        rst           = 1'b1;
        rf_scramble   = 1'b1;
        sat_valid     = 1'b0;
        // Request held from the start: must wait until the sweep finishes
        in_valid      = 1'b1;
        in_reg_write  = 1'b1;
        in_mem_to_reg = 1'b0;
        in_rd         = 5'd3;
        in_alu_result = 32'h33;
        in_mem_data   = 32'hBAD0;
        #1;
        chk("rst_wr_en", {31'd0, r_wr_en}, 32'd0);
        chk("rst_addr", {27'd0, r_addr_in}, 32'd0);
        chk("rst_data", r_data_in, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_wb_count", {16'd0, wb_count}, 32'd0);
        chk("rst_sat_ready", {31'd0, s_in_ready}, 32'd0);
        chk("rst_sat_init", {31'd0, s_init_done}, 32'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rf_scramble = 1'b0;
        rst = 1'b0;

        // Partial sweep up to address 12, then an asynchronous reset
        for (int i = 0; i <= 12; i++) begin
            tick();
            chk("sweep1_wr_en", {31'd0, r_wr_en}, 32'd1);
            chk("sweep1_addr", {27'd0, r_addr_in}, i);
            chk("sweep1_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        end
        #2 rst = 1'b1;
        #1;
        chk("abort_wr_en", {31'd0, r_wr_en}, 32'd0);
        chk("abort_addr", {27'd0, r_addr_in}, 32'd0);
        chk("abort_init_done", {31'd0, init_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full sweep: 32 consecutive zero writes, request held off
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("sweep_wr_en", {31'd0, r_wr_en}, 32'd1);
            chk("sweep_addr", {27'd0, r_addr_in}, i);
            chk("sweep_data", r_data_in, 32'd0);
            chk("sweep_in_ready", {31'd0, in_ready}, 32'd0);
            chk("sweep_fwd_valid", {31'd0, fwd_valid}, 32'd0);
            chk("sweep_init_done", {31'd0, init_done}, 32'd0);
            chk("sweep_wb_count", {16'd0, wb_count}, 32'd0);
            if (i == 0) begin
                chk("sat_init_done", {31'd0, s_init_done}, 32'd1);
                chk("sat_in_ready", {31'd0, s_in_ready}, 32'd1);
            end
        end
        $display("sweep: 32 clear writes issued");

        tick();
        chk("run_wr_en", {31'd0, r_wr_en}, 32'd0);
        chk("run_init_done", {31'd0, init_done}, 32'd1);
        chk("run_in_ready", {31'd0, in_ready}, 32'd1);
        chk("run_wb_count", {16'd0, wb_count}, 32'd0);
        for (int k = 0; k < 32; k++) chk("clear_readback", rf[k], 32'd0);

        // Held request accepted on the first RUN cycle
        tick();
        $display("txn: held rd=3 alu=33");
        chk_port("held", 1'b1, 5'd3, 32'h33);
        chk("held_wb_count", {16'd0, wb_count}, 32'd1);

        // ALU select, then load select
        in_rd = 5'd5; in_alu_result = 32'h1234; in_mem_data = 32'hDEAD;
        tick();
        $display("txn: rd=5 mem_to_reg=0");
        chk_port("alu_sel", 1'b1, 5'd5, 32'h1234);
        chk("alu_sel_wb_count", {16'd0, wb_count}, 32'd2);
        in_mem_to_reg = 1'b1;
        tick();
        $display("txn: rd=5 mem_to_reg=1");
        chk_port("mem_sel", 1'b1, 5'd5, 32'hDEAD);
        chk("mem_sel_wb_count", {16'd0, wb_count}, 32'd3);

        // Suppressed writes: rd=0, then reg_write=0
        in_mem_to_reg = 1'b0; in_rd = 5'd0; in_alu_result = 32'h99;
        tick();
        $display("txn: rd=0 reg_write=1");
        chk("rd0_wr_en", {31'd0, r_wr_en}, 32'd0);
        chk("rd0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        chk("rd0_wb_count", {16'd0, wb_count}, 32'd3);
        in_rd = 5'd7; in_reg_write = 1'b0; in_alu_result = 32'h77;
        tick();
        $display("txn: rd=7 reg_write=0");
        chk("nowr_wr_en", {31'd0, r_wr_en}, 32'd0);
        chk("nowr_wb_count", {16'd0, wb_count}, 32'd3);
        in_valid = 1'b0; in_alu_result = 32'h55;
        tick();
        chk("idle_wr_en", {31'd0, r_wr_en}, 32'd0);
        chk("idle_addr_hold", {27'd0, r_addr_in}, 32'd7);
        chk("idle_data_hold", r_data_in, 32'h77);
        chk("rf0_readback", rf[0], 32'd0);
        chk("rf5_readback", rf[5], 32'hDEAD);

        // Ten back-to-back writes; the 3-bit counter instance saturates
        in_valid = 1'b1; sat_valid = 1'b1; in_reg_write = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_rd = 5'(i);
            in_alu_result = i;
            tick();
            $display("txn: b2b rd=%0d alu=%0d", i, i);
            chk_port("b2b", 1'b1, 5'(i), i);
            chk("b2b_sat_wr_en", {31'd0, s_wr_en}, 32'd1);
            chk("sat_wb_count", {29'd0, s_wb_count}, (i < 7) ? i : 7);
        end
        in_valid = 1'b0; sat_valid = 1'b0;
        tick();
        chk("b2b_end_wr_en", {31'd0, r_wr_en}, 32'd0);
        chk("b2b_wb_count", {16'd0, wb_count}, 32'd13);
        chk("sat_final", {29'd0, s_wb_count}, 32'd7);
        for (int i = 1; i <= 10; i++) chk("b2b_readback", rf[i], i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_write_ctrl.md
Name: reg_write_ctrl

Overview:
Write-side controller for the pipeline register file. It owns the file's single write port (r_wr_en / r_addr_in / r_data_in) and drives it in two phases. After reset it clears every register to zero. It then runs as the MEM/WB writeback register, selecting ALU or load data and suppressing writes to $zero. It also exports a forwarding copy of the in-flight write and a saturating retired-write counter.

Parameters:
DWIDTH, 32, data width of the register file
AWIDTH, 5, register address width; the file has 2**AWIDTH entries
CLEAR_EN, 1, 1 = run the post-reset clear sweep; 0 = enter RUN directly
CWIDTH, 16, width of the retired-write counter

Ports:
r_clk  input  1  clock, rising edge
r_rst  input  1  asynchronous reset, active-high
in_valid  input  1  writeback request valid from MEM stage
in_ready  output  1  controller accepts a request this cycle
in_reg_write  input  1  instruction writes a register
in_mem_to_reg  input  1  1 = write in_mem_data, 0 = write in_alu_result
in_rd  input  AWIDTH  destination register
in_alu_result  input  DWIDTH  ALU result
in_mem_data  input  DWIDTH  load data
r_wr_en  output  1  register-file write enable
r_addr_in  output  AWIDTH  register-file write address
r_data_in  output  DWIDTH  register-file write data
fwd_valid  output  1  forwarding entry valid (equals r_wr_en)
fwd_addr  output  AWIDTH  forwarding address (equals r_addr_in)
fwd_data  output  DWIDTH  forwarding data (equals r_data_in)
init_done  output  1  clear sweep finished
wb_count  output  CWIDTH  retired register writes, saturating

Behaviour:
- Reset (asynchronous, r_rst=1):
  - state=CLEAR (or RUN if CLEAR_EN=0); sweep counter=0.
  - r_wr_en=0, r_addr_in=0, r_data_in=0, in_ready=0, init_done=0, wb_count=0.
  - Asserting r_rst mid-sweep or mid-run aborts everything. The sweep restarts from address 0 after release.
- CLEAR state:
  - Each cycle, registered outputs: r_wr_en=1, r_addr_in=cnt, r_data_in=0; cnt increments.
  - The first clear write appears on the first rising edge after reset release.
  - Exactly 2**AWIDTH write cycles (32 by default), addresses 0..31 in order, no gaps.
  - On the edge after the address-31 write, go to RUN. That edge sets init_done=1 and r_wr_en=0; init_done stays 1 until reset.
  - in_ready=0 throughout. in_valid is ignored and upstream must hold its request.
  - Clear writes do not increment wb_count.
- RUN state:
  - in_ready=1 combinationally; no backpressure, since the write port accepts every cycle.
  - Accept = in_valid & in_ready. Latency is 1 cycle; on the following edge:
    - r_wr_en = in_reg_write & (in_rd != 0).
    - r_addr_in = in_rd.
    - r_data_in = in_mem_to_reg ? in_mem_data : in_alu_result.
  - No accept: r_wr_en=0 on the next edge; r_addr_in and r_data_in hold their previous values.
  - Back-to-back accepts give one write per cycle, in order.
  - Accepted requests with in_reg_write=0 or in_rd=0 produce r_wr_en=0 and are not counted.
- Forwarding:
  - fwd_valid, fwd_addr and fwd_data are combinational copies of r_wr_en, r_addr_in and r_data_in.
  - fwd_valid=0 during CLEAR, so clear writes are never forwarded.
- wb_count:
  - Increments on every edge where a RUN-state write with r_wr_en=1 is issued.
  - Saturates at 2**CWIDTH-1; no wrap.
- With CLEAR_EN=0:
  - RUN is entered immediately and init_done=1 from the first edge after reset release.
  - Registers power up to whatever the register file's own reset produces.

Test Plan:
- Reset released, CLEAR_EN=1 -> r_wr_en=1 for exactly 32 consecutive cycles with r_addr_in 0..31 and r_data_in=0. Then init_done=1, in_ready=1, wb_count=0; readback of all 32 registers returns 0.
- In RUN, accept {reg_write=1, mem_to_reg=0, rd=5, alu=0x1234, mem=0xDEAD} -> next cycle r_wr_en=1, r_addr_in=5, r_data_in=0x1234, fwd_* identical, wb_count=1. The same request with mem_to_reg=1 -> r_data_in=0xDEAD.
- Accept rd=0 with reg_write=1, then rd=7 with reg_write=0 -> r_wr_en=0 on both following cycles, wb_count unchanged, and register 0 reads 0.
- Ten back-to-back accepts writing rd=i, alu=i for i=1..10 -> ten consecutive write cycles in order, wb_count=10, readback reg i == i.
- in_valid=1 held during the sweep -> in_ready=0 and no request write occurs before init_done. The request is accepted on the first RUN cycle.
- r_rst pulsed while the sweep is at address 12 -> outputs return to 0 asynchronously, and the sweep restarts at address 0 for a full 32 cycles. Separately, with CWIDTH=3, nine writes -> wb_count saturates at 7.
